// File: rtl/fetch_buffer.sv
// fetch_buffer: sequential instruction fetch with a credit-limited prefetch FIFO feeding decode.
// Define FETCH_MISALIGN_CHECK_EN to turn misaligned redirect targets into a misalign exception entry.

module fetch_buffer #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        imem_resp_err,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        out_fault,
   output logic        out_misalign
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic        fault;
`ifdef FETCH_MISALIGN_CHECK_EN
      logic        misalign;
`endif
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        push_entry;
   entry_t        head;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_cnt_q, drop_cnt_d;
   logic [63:0]   fetch_pc_q, fetch_pc_d;
   logic [63:0]   resp_pc_q, resp_pc_d;
   logic          halted_q, halted_d;

   logic          req_fire;
   logic          resp_keep;
   logic          push;
   logic          pop;
   logic          mis_redirect;
   logic [CW:0]   occupancy;

   // Credit rule: buffered entries plus outstanding requests never exceed DEPTH.
   assign occupancy      = {1'b0, count_q} + {1'b0, inflight_q};
   assign imem_req_valid = !rst && !redirect && !halted_q && (occupancy < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign resp_keep = imem_resp_valid && !redirect && !halted_q && (drop_cnt_q == '0);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready && !redirect;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic        mis_pend_q;
   logic [63:0] mis_pc_q;
   logic        mis_push;

   assign mis_redirect = redirect && (redirect_pc[1:0] != 2'b00);
   // Halted is set alongside mis_pend_q, so this push never collides with a response push.
   assign mis_push     = mis_pend_q && !redirect;
   assign push         = resp_keep || mis_push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mis_pend_q <= 1'b0;
         mis_pc_q   <= '0;
      end else begin
         mis_pend_q <= mis_redirect;
         if (mis_redirect) mis_pc_q <= redirect_pc;
      end
   end
`else
   logic unused_redirect_lsb;

   assign mis_redirect        = 1'b0;
   assign push                = resp_keep;
   assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

   always_comb begin
      push_entry       = '0;
      push_entry.instr = imem_resp_err ? 32'h0 : imem_resp_data;
      push_entry.pc    = resp_pc_q;
      push_entry.fault = imem_resp_err;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (mis_push) begin
         push_entry.instr    = '0;
         push_entry.pc       = mis_pc_q;
         push_entry.fault    = 1'b0;
         push_entry.misalign = 1'b1;
      end
`endif
   end

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      drop_cnt_d = drop_cnt_q;
      halted_d   = halted_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
      count_d    = count_q + CW'(push) - CW'(pop);

      if (req_fire) fetch_pc_d = fetch_pc_q + 64'd4;
      if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
      if (resp_keep) begin
         resp_pc_d = resp_pc_q + 64'd4;
         if (imem_resp_err) halted_d = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

      // Redirect wins: everything still in flight (minus this cycle's response) must be dropped.
      if (redirect) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         halted_d   = mis_redirect;
         fetch_pc_d = {redirect_pc[63:2], 2'b00};
         resp_pc_d  = {redirect_pc[63:2], 2'b00};
         drop_cnt_d = inflight_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         inflight_q <= '0;
         drop_cnt_q <= '0;
         halted_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         halted_q   <= halted_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only observable through the reset count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   assign head      = mem_q[rd_ptr_q];
   assign out_instr = out_valid ? head.instr : 32'h0;
   assign out_pc    = out_valid ? head.pc    : 64'h0;
   assign out_fault = out_valid && head.fault;
`ifdef FETCH_MISALIGN_CHECK_EN
   assign out_misalign = out_valid && head.misalign;
`else
   assign out_misalign = 1'b0;
`endif

endmodule
